// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-requester memory arbiter: FSM encoding
// and default widths. Imported by the RTL and by the testbench.
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_e;

endpackage : mem_arbiter_pkg

// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals of the arbiter.
// Handshake: a requester raises Req (with We/Addr/WData stable) and keeps it
// high until its one-cycle Ack; it drops Req on the edge ending the Ack cycle.
// Memory side: Mem_En/Mem_Write_EN are active low, sampled by the memory on
// the falling edge; Mem_DOut is returned on that same falling edge.
interface mem_arbiter_if #(
    parameter int AddrWidth = 8,
    parameter int DataWidth = 16
);
    logic                 Req0, Req1;
    logic                 We0, We1;
    logic [AddrWidth-1:0] Addr0, Addr1;
    logic [DataWidth-1:0] WData0, WData1;
    logic                 Ack0, Ack1;
    logic [DataWidth-1:0] RData0, RData1;
    logic                 Grant;
    logic                 Busy;
    logic [AddrWidth-1:0] Mem_Address;
    logic [DataWidth-1:0] Mem_DIn;
    logic                 Mem_Write_EN;
    logic                 Mem_En;
    logic [DataWidth-1:0] Mem_DOut;

    // Arbiter view
    modport slave (
        input  Req0, Req1, We0, We1, Addr0, Addr1, WData0, WData1, Mem_DOut,
        output Ack0, Ack1, RData0, RData1, Grant, Busy,
               Mem_Address, Mem_DIn, Mem_Write_EN, Mem_En
    );

    // Requesters + memory view
    modport master (
        output Req0, Req1, We0, We1, Addr0, Addr1, WData0, WData1, Mem_DOut,
        input  Ack0, Ack1, RData0, RData1, Grant, Busy,
               Mem_Address, Mem_DIn, Mem_Write_EN, Mem_En
    );
endinterface : mem_arbiter_if

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone request wins; on a tie the requester
// that was not served last wins.
module rr_pick2 (
    input  logic Req0,
    input  logic Req1,
    input  logic last,
    output logic winner
);
    // Winner select; with no request the result is unused by the caller
    always_comb begin
        if (Req0 && Req1) winner = ~last;
        else              winner = Req1;
    end
endmodule : rr_pick2

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a falling-edge single-port memory.
// Each access takes IDLE -> ACCESS -> RESP; the memory operation happens on
// the falling edge inside ACCESS and the Ack pulse is issued in RESP.
// The width parameters must match those of the connected interface.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AddrWidth = ADDR_W_DEF,
    parameter int DataWidth = DATA_W_DEF
) (
    input  logic          Clk,
    input  logic          Reset_N,
    mem_arbiter_if.slave  bus,
    output state_e        Dbg_State
);

    state_e               state_q, state_d;
    logic                 last_q, last_d;
    logic                 grant_q, grant_d;
    logic                 busy_q, busy_d;
    logic                 we_q, we_d;
    logic                 mem_en_q, mem_en_d;
    logic                 mem_we_q, mem_we_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [DataWidth-1:0] din_q, din_d;
    logic                 ack0_q, ack0_d;
    logic                 ack1_q, ack1_d;
    logic [DataWidth-1:0] rdata0_q, rdata0_d;
    logic [DataWidth-1:0] rdata1_q, rdata1_d;

    logic                 req_any;
    logic                 winner;

    assign req_any = bus.Req0 | bus.Req1;

    rr_pick2 u_pick (
        .Req0   (bus.Req0),
        .Req1   (bus.Req1),
        .last   (last_q),
        .winner (winner)
    );

    // State and registered-output update; reset aborts any transaction
    always_ff @(posedge Clk) begin
        if (!Reset_N) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            grant_q  <= 1'b0;
            busy_q   <= 1'b0;
            we_q     <= 1'b0;
            mem_en_q <= 1'b1;
            mem_we_q <= 1'b1;
            addr_q   <= '0;
            din_q    <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            grant_q  <= grant_d;
            busy_q   <= busy_d;
            we_q     <= we_d;
            mem_en_q <= mem_en_d;
            mem_we_q <= mem_we_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Next-state: any request starts an access; ACCESS and RESP last one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_any) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output next-values: latch winner in IDLE, strobe memory in ACCESS,
    // ack and capture read data on the ACCESS->RESP edge
    always_comb begin
        last_d   = last_q;
        grant_d  = grant_q;
        busy_d   = busy_q;
        we_d     = we_q;
        mem_en_d = 1'b1;
        mem_we_d = 1'b1;
        addr_d   = addr_q;
        din_d    = din_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (req_any) begin
                    grant_d  = winner;
                    busy_d   = 1'b1;
                    addr_d   = winner ? bus.Addr1  : bus.Addr0;
                    din_d    = winner ? bus.WData1 : bus.WData0;
                    we_d     = winner ? bus.We1    : bus.We0;
                    mem_en_d = 1'b0;
                    mem_we_d = winner ? ~bus.We1 : ~bus.We0;
                end
            end
            ACCESS: begin
                busy_d = 1'b1;
                last_d = grant_q;
                if (grant_q) begin
                    ack1_d = 1'b1;
                    if (!we_q) rdata1_d = bus.Mem_DOut;
                end else begin
                    ack0_d = 1'b1;
                    if (!we_q) rdata0_d = bus.Mem_DOut;
                end
            end
            RESP: begin
                busy_d = 1'b0;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    assign bus.Ack0         = ack0_q;
    assign bus.Ack1         = ack1_q;
    assign bus.RData0       = rdata0_q;
    assign bus.RData1       = rdata1_q;
    assign bus.Grant        = grant_q;
    assign bus.Busy         = busy_q;
    assign bus.Mem_Address  = addr_q;
    assign bus.Mem_DIn      = din_q;
    assign bus.Mem_Write_EN = mem_we_q;
    assign bus.Mem_En       = mem_en_q;
    assign Dbg_State        = state_q;

endmodule : mem_arbiter
